// File: rtl/gcn_host_driver.sv
// gcn_host_driver: sequences one accelerator pass. It streams the weight
// column and the sparse input pairs out of local word memory, waits for the
// result header, then forwards the result burst to the sink.
module gcn_host_driver #(
  parameter int unsigned WEIGHT_ROW_SIZE = 32,
  parameter int unsigned NNZ_MAX         = 100,
  parameter int unsigned RESULT_WORDS    = 200,
  parameter int unsigned TIMEOUT         = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  w_col,
  input  logic [7:0]  nnz,
  output logic        mem_rd_en,
  output logic [8:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        i_req,
  output logic        i_cmd,
  output logic [15:0] i_p,
  input  logic        o_rdy,
  input  logic [15:0] o_p,
  output logic        res_valid,
  output logic [7:0]  res_idx,
  output logic [15:0] res_data,
  output logic [15:0] res_hdr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = 17;
  localparam int unsigned AW = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WADDR    = 3'd2,
    WDATA    = 3'd3,
    IDATA    = 3'd4,
    WAIT_RES = 3'd5,
    RECV     = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic [7:0]      nnz_q;
  logic [7:0]      nnz_d;
  logic [7:0]      w_col_q;
  logic [7:0]      w_col_d;
  logic            rd_pend;
  logic            start_ok_c;
  logic [CW-1:0]   pairs_c;
  logic [AW-1:0]   rd_last_c;
  logic            mem_rd_en_d;
  logic [8:0]      mem_addr_d;
  logic            i_req_d;
  logic            i_cmd_d;
  logic [15:0]     i_p_d;
  logic            res_valid_d;
  logic [7:0]      res_idx_d;
  logic [15:0]     res_data_d;
  logic [15:0]     res_hdr_d;
  logic            busy_d;
  logic            done_d;
  logic            err_d;

  // A pass is only launched for a nonzero count within the supported range.
  assign start_ok_c = (nnz != 8'd0) && (32'(nnz) <= NNZ_MAX);
  // Number of input words (row/col pair + data) in the IDATA phase.
  assign pairs_c    = CW'({nnz_q, 1'b0});
  // Address of the final memory read: weight words followed by input words.
  assign rd_last_c  = AW'(2 * WEIGHT_ROW_SIZE) + AW'({nnz_q, 1'b0}) - AW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start && start_ok_c) next_state = REQ;
      REQ:      next_state = WADDR;
      WADDR:    next_state = WDATA;
      WDATA:    if (cnt == CW'(2 * WEIGHT_ROW_SIZE - 1)) next_state = IDATA;
      IDATA:    if (cnt == pairs_c - CW'(1)) next_state = WAIT_RES;
      WAIT_RES: begin
        if (o_rdy)                            next_state = RECV;
        else if (cnt == CW'(TIMEOUT - 1))     next_state = DONE;
      end
      RECV:     if (cnt == CW'(RESULT_WORDS - 1)) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next values of all registered outputs; memory reads run two cycles ahead
  // of i_p so the word stream after WADDR has no bubbles.
  always_comb begin
    cnt_d       = (next_state == state && state != IDLE) ? cnt + CW'(1) : '0;
    nnz_d       = nnz_q;
    w_col_d     = w_col_q;
    err_d       = err;
    res_hdr_d   = res_hdr;
    mem_rd_en_d = mem_rd_en;
    mem_addr_d  = mem_addr;
    i_req_d     = (next_state == REQ);
    i_cmd_d     = (state == IDATA) && (cnt == pairs_c - CW'(2));
    i_p_d       = '0;
    res_valid_d = (state == RECV);
    res_idx_d   = (state == RECV) ? cnt[7:0] : '0;
    res_data_d  = (state == RECV) ? o_p : '0;
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);

    if (rd_pend)                  i_p_d = mem_rdata;
    else if (next_state == WADDR) i_p_d = {8'h00, w_col_q & 8'hFE};

    if (state == IDLE && start) begin
      err_d = !start_ok_c;
      if (start_ok_c) begin
        nnz_d       = nnz;
        w_col_d     = w_col;
        mem_rd_en_d = 1'b1;
        mem_addr_d  = '0;
      end
    end

    if (mem_rd_en) begin
      if ({1'b0, mem_addr} == rd_last_c) begin
        mem_rd_en_d = 1'b0;
        mem_addr_d  = '0;
      end else begin
        mem_addr_d  = mem_addr + 9'd1;
      end
    end

    if (state == WAIT_RES && next_state == DONE) err_d = 1'b1;
    if (state == WAIT_RES && o_rdy)              res_hdr_d = o_p;
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      nnz_q     <= '0;
      w_col_q   <= '0;
      rd_pend   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      i_req     <= 1'b0;
      i_cmd     <= 1'b0;
      i_p       <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      res_hdr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      nnz_q     <= nnz_d;
      w_col_q   <= w_col_d;
      rd_pend   <= mem_rd_en;
      mem_rd_en <= mem_rd_en_d;
      mem_addr  <= mem_addr_d;
      i_req     <= i_req_d;
      i_cmd     <= i_cmd_d;
      i_p       <= i_p_d;
      res_valid <= res_valid_d;
      res_idx   <= res_idx_d;
      res_data  <= res_data_d;
      res_hdr   <= res_hdr_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
